// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle control unit: states, ALU codes,
// opcode/func values, datapath select codes and decoded-instruction indices.
package mc_pkg;

    typedef enum logic [2:0] {
        StIf  = 3'b000,
        StId  = 3'b001,
        StExe = 3'b010,
        StMem = 3'b011,
        StWb  = 3'b100
    } state_e;

    localparam logic [3:0] AlucAdd = 4'b0000;
    localparam logic [3:0] AlucSub = 4'b0100;
    localparam logic [3:0] AlucAnd = 4'b0001;
    localparam logic [3:0] AlucOr  = 4'b0101;
    localparam logic [3:0] AlucXor = 4'b0010;
    localparam logic [3:0] AlucLui = 4'b0110;
    localparam logic [3:0] AlucSll = 4'b0011;
    localparam logic [3:0] AlucSrl = 4'b0111;
    localparam logic [3:0] AlucSra = 4'b1111;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpXori  = 6'b001110;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpLui   = 6'b001111;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;

    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnXor = 6'b100110;
    localparam logic [5:0] FnSll = 6'b000000;
    localparam logic [5:0] FnSrl = 6'b000010;
    localparam logic [5:0] FnSra = 6'b000011;
    localparam logic [5:0] FnJr  = 6'b001000;

    localparam logic [1:0] SrcbRegB  = 2'b00;
    localparam logic [1:0] SrcbFour  = 2'b01;
    localparam logic [1:0] SrcbImm   = 2'b10;
    localparam logic [1:0] SrcbImmSh = 2'b11;

    localparam logic [1:0] PcAlu    = 2'b00;
    localparam logic [1:0] PcAluOut = 2'b01;
    localparam logic [1:0] PcRegA   = 2'b10;
    localparam logic [1:0] PcJump   = 2'b11;

    // Bit positions in the one-hot instruction vector from mc_decode.
    localparam int unsigned IAdd  = 0;
    localparam int unsigned ISub  = 1;
    localparam int unsigned IAnd  = 2;
    localparam int unsigned IOr   = 3;
    localparam int unsigned IXor  = 4;
    localparam int unsigned ISll  = 5;
    localparam int unsigned ISrl  = 6;
    localparam int unsigned ISra  = 7;
    localparam int unsigned IJr   = 8;
    localparam int unsigned IAddi = 9;
    localparam int unsigned IAndi = 10;
    localparam int unsigned IOri  = 11;
    localparam int unsigned IXori = 12;
    localparam int unsigned ILw   = 13;
    localparam int unsigned ISw   = 14;
    localparam int unsigned IBeq  = 15;
    localparam int unsigned IBne  = 16;
    localparam int unsigned ILui  = 17;
    localparam int unsigned IJ    = 18;
    localparam int unsigned IJal  = 19;
    localparam int unsigned NumInstr = 20;

endpackage

// File: rtl/mc_decode.sv
// Combinational op/func decoder: one-hot instruction flags plus a legal bit.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0]          op_i,
    input  logic [5:0]          func_i,
    output logic [NumInstr-1:0] inst_o,
    output logic                legal_o
);

    always_comb begin
        inst_o = '0;
        unique case (op_i)
            OpRtype: begin
                unique case (func_i)
                    FnAdd:   inst_o[IAdd] = 1'b1;
                    FnSub:   inst_o[ISub] = 1'b1;
                    FnAnd:   inst_o[IAnd] = 1'b1;
                    FnOr:    inst_o[IOr]  = 1'b1;
                    FnXor:   inst_o[IXor] = 1'b1;
                    FnSll:   inst_o[ISll] = 1'b1;
                    FnSrl:   inst_o[ISrl] = 1'b1;
                    FnSra:   inst_o[ISra] = 1'b1;
                    FnJr:    inst_o[IJr]  = 1'b1;
                    default: ;
                endcase
            end
            OpAddi:  inst_o[IAddi] = 1'b1;
            OpAndi:  inst_o[IAndi] = 1'b1;
            OpOri:   inst_o[IOri]  = 1'b1;
            OpXori:  inst_o[IXori] = 1'b1;
            OpLw:    inst_o[ILw]   = 1'b1;
            OpSw:    inst_o[ISw]   = 1'b1;
            OpBeq:   inst_o[IBeq]  = 1'b1;
            OpBne:   inst_o[IBne]  = 1'b1;
            OpLui:   inst_o[ILui]  = 1'b1;
            OpJ:     inst_o[IJ]    = 1'b1;
            OpJal:   inst_o[IJal]  = 1'b1;
            default: ;
        endcase
    end

    assign legal_o = |inst_o;

endmodule

// File: rtl/mc_cu.sv
// Multi-cycle MIPS-subset control unit: IF/ID/EXE/MEM/WB sequencer driving
// the shared ALU, single memory port and register file, stalling on mem_ready.
module mc_cu
    import mc_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       z,
    input  logic       mem_ready,
    output logic       wpc,
    output logic       wir,
    output logic       wmem,
    output logic       wreg,
    output logic       iord,
    output logic       regrt,
    output logic       m2reg,
    output logic       jal,
    output logic       shift,
    output logic       sext,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [3:0] aluc,
    output logic [1:0] pcsource,
    output logic [2:0] state,
    output logic       illegal
);

    logic [NumInstr-1:0] inst;
    logic                legal;

    mc_decode u_decode (
        .op_i    (op),
        .func_i  (func),
        .inst_o  (inst),
        .legal_o (legal)
    );

    logic is_shift, is_r_alu, is_i_alu, is_branch, is_mem, sext_op, taken;
    logic [3:0] alu_op;

    assign is_shift  = inst[ISll] | inst[ISrl] | inst[ISra];
    assign is_r_alu  = inst[IAdd] | inst[ISub] | inst[IAnd] | inst[IOr] | inst[IXor] | is_shift;
    assign is_i_alu  = inst[IAddi] | inst[IAndi] | inst[IOri] | inst[IXori] | inst[ILui];
    assign is_branch = inst[IBeq] | inst[IBne];
    assign is_mem    = inst[ILw] | inst[ISw];
    assign sext_op   = inst[IAddi] | is_mem | is_branch;
    assign taken     = (inst[IBeq] & z) | (inst[IBne] & ~z);

    always_comb begin
        alu_op = AlucAdd;
        if (inst[ISub] | is_branch)       alu_op = AlucSub;
        else if (inst[IAnd] | inst[IAndi]) alu_op = AlucAnd;
        else if (inst[IOr] | inst[IOri])   alu_op = AlucOr;
        else if (inst[IXor] | inst[IXori]) alu_op = AlucXor;
        else if (inst[ILui])               alu_op = AlucLui;
        else if (inst[ISll])               alu_op = AlucSll;
        else if (inst[ISrl])               alu_op = AlucSrl;
        else if (inst[ISra])               alu_op = AlucSra;
    end

    state_e state_q, state_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= StIf;
        else       state_q <= state_d;
    end

    assign state = state_q;

    always_comb begin
        state_d  = StIf;
        wpc      = 1'b0;
        wir      = 1'b0;
        wmem     = 1'b0;
        wreg     = 1'b0;
        iord     = 1'b0;
        regrt    = 1'b0;
        m2reg    = 1'b0;
        jal      = 1'b0;
        shift    = 1'b0;
        sext     = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = SrcbRegB;
        aluc     = AlucAdd;
        pcsource = PcAlu;
        illegal  = 1'b0;

        case (state_q)
            StIf: begin
                alusrcb = SrcbFour;
                if (mem_ready) begin
                    wir     = 1'b1;
                    wpc     = 1'b1;
                    state_d = StId;
                end else begin
                    state_d = StIf;
                end
            end
            StId: begin
                // Branch target is computed here so EXE can just select it.
                alusrcb = SrcbImmSh;
                if (!legal) begin
                    illegal = 1'b1;
                end else if (inst[IJ] | inst[IJal]) begin
                    wpc      = 1'b1;
                    pcsource = PcJump;
                    wreg     = inst[IJal];
                    jal      = inst[IJal];
                end else if (inst[IJr]) begin
                    wpc      = 1'b1;
                    pcsource = PcRegA;
                end else begin
                    state_d = StExe;
                end
            end
            StExe: begin
                alusrca = 1'b1;
                aluc    = alu_op;
                sext    = sext_op;
                if (is_branch) begin
                    if (taken) begin
                        wpc      = 1'b1;
                        pcsource = PcAluOut;
                    end
                end else if (is_mem) begin
                    alusrcb = SrcbImm;
                    state_d = StMem;
                end else if (is_r_alu) begin
                    shift   = is_shift;
                    state_d = StWb;
                end else if (is_i_alu) begin
                    alusrcb = SrcbImm;
                    state_d = StWb;
                end
            end
            StMem: begin
                iord = 1'b1;
                if (inst[ISw]) begin
                    wmem    = 1'b1;
                    state_d = mem_ready ? StIf : StMem;
                end else if (inst[ILw]) begin
                    state_d = mem_ready ? StWb : StMem;
                end else begin
                    state_d = StMem;
                end
            end
            StWb: begin
                wreg  = 1'b1;
                m2reg = inst[ILw];
                regrt = inst[ILw] | is_i_alu;
            end
            default: state_d = StIf;
        endcase

        // The state register is already IF here; this blocks the IF fetch strobes.
        if (reset) begin
            wpc     = 1'b0;
            wir     = 1'b0;
            wmem    = 1'b0;
            wreg    = 1'b0;
            illegal = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_cu.sv
// Directed, table-driven bench for mc_cu: one row per clock cycle with the
// full expected output bundle, plus a reactive lw wait-state sequence.
module tb_mc_cu;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'd0;
    logic [5:0] func = 6'd0;
    logic       z = 1'b0;
    logic       mem_ready = 1'b1;
    logic       wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift, sext, alusrca, illegal;
    logic [1:0] alusrcb, pcsource;
    logic [3:0] aluc;
    logic [2:0] state;

    mc_cu dut (
        .clock     (clock),
        .reset     (reset),
        .op        (op),
        .func      (func),
        .z         (z),
        .mem_ready (mem_ready),
        .wpc       (wpc),
        .wir       (wir),
        .wmem      (wmem),
        .wreg      (wreg),
        .iord      (iord),
        .regrt     (regrt),
        .m2reg     (m2reg),
        .jal       (jal),
        .shift     (shift),
        .sext      (sext),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .aluc      (aluc),
        .pcsource  (pcsource),
        .state     (state),
        .illegal   (illegal)
    );

    always #5 clock = ~clock;

    // Bundle: state | wpc wir wmem wreg | iord regrt m2reg jal | shift sext srca | srcb | aluc | pcsrc | ill
    localparam logic [22:0] IFN   = 23'b000_0000_0000_000_01_0000_00_0;
    localparam logic [22:0] IFR   = 23'b000_1100_0000_000_01_0000_00_0;
    localparam logic [22:0] IDN   = 23'b001_0000_0000_000_11_0000_00_0;
    localparam logic [22:0] IDJ   = 23'b001_1000_0000_000_11_0000_11_0;
    localparam logic [22:0] IDJAL = 23'b001_1001_0001_000_11_0000_11_0;
    localparam logic [22:0] IDJR  = 23'b001_1000_0000_000_11_0000_10_0;
    localparam logic [22:0] IDILL = 23'b001_0000_0000_000_11_0000_00_1;
    localparam logic [22:0] EXADD = 23'b010_0000_0000_001_00_0000_00_0;
    localparam logic [22:0] EXSLL = 23'b010_0000_0000_101_00_0011_00_0;
    localparam logic [22:0] EXSRA = 23'b010_0000_0000_101_00_1111_00_0;
    localparam logic [22:0] EXIMM = 23'b010_0000_0000_011_10_0000_00_0;
    localparam logic [22:0] EXORI = 23'b010_0000_0000_001_10_0101_00_0;
    localparam logic [22:0] EXLUI = 23'b010_0000_0000_001_10_0110_00_0;
    localparam logic [22:0] BRT   = 23'b010_1000_0000_011_00_0100_01_0;
    localparam logic [22:0] BRN   = 23'b010_0000_0000_011_00_0100_00_0;
    localparam logic [22:0] MEMLW = 23'b011_0000_1000_000_00_0000_00_0;
    localparam logic [22:0] MEMSW = 23'b011_0010_1000_000_00_0000_00_0;
    localparam logic [22:0] WBR   = 23'b100_0001_0000_000_00_0000_00_0;
    localparam logic [22:0] WBI   = 23'b100_0001_0100_000_00_0000_00_0;
    localparam logic [22:0] WBLW  = 23'b100_0001_0110_000_00_0000_00_0;

    localparam logic [5:0] R = 6'b000000;

    typedef struct {
        string       name;
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  func;
        logic        z;
        logic        rdy;
        logic [22:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [22:0] got_vec();
        return {state, wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift, sext, alusrca,
                alusrcb, aluc, pcsource, illegal};
    endfunction

    task automatic add(input string n, input logic r, input logic [5:0] o, input logic [5:0] f,
                       input logic zz, input logic rd, input logic [22:0] e);
        vec_t v;
        v.name = n; v.rst = r; v.op = o; v.func = f; v.z = zz; v.rdy = rd; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", n, act, exp);
        end
    endtask

    int  cycles, waits;
    bit  done, iord_ok, wb_ok;

    initial begin
        add("reset",        1, R, 6'b100000, 0, 1, IFN);
        add("add_if",       0, R, 6'b100000, 0, 1, IFR);
        add("add_id",       0, R, 6'b100000, 1, 0, IDN);
        add("add_exe",      0, R, 6'b100000, 1, 0, EXADD);
        add("add_wb",       0, R, 6'b100000, 1, 0, WBR);
        add("if_stall",     0, 6'b100011, 0, 0, 0, IFN);
        add("lw_if",        0, 6'b100011, 0, 0, 1, IFR);
        add("lw_id",        0, 6'b100011, 0, 0, 1, IDN);
        add("lw_exe",       0, 6'b100011, 0, 0, 1, EXIMM);
        add("lw_mem_w1",    0, 6'b100011, 0, 0, 0, MEMLW);
        add("lw_mem_w2",    0, 6'b100011, 0, 1, 0, MEMLW);
        add("lw_mem_rdy",   0, 6'b100011, 0, 0, 1, MEMLW);
        add("lw_wb",        0, 6'b100011, 0, 0, 0, WBLW);
        add("beq_if",       0, 6'b000100, 0, 0, 1, IFR);
        add("beq_id",       0, 6'b000100, 0, 1, 1, IDN);
        add("beq_z1",       0, 6'b000100, 0, 1, 1, BRT);
        add("beq2_if",      0, 6'b000100, 0, 0, 1, IFR);
        add("beq2_id",      0, 6'b000100, 0, 0, 1, IDN);
        add("beq_z0",       0, 6'b000100, 0, 0, 1, BRN);
        add("bne_if",       0, 6'b000101, 0, 0, 1, IFR);
        add("bne_id",       0, 6'b000101, 0, 0, 1, IDN);
        add("bne_z0",       0, 6'b000101, 0, 0, 1, BRT);
        add("bne2_if",      0, 6'b000101, 0, 0, 1, IFR);
        add("bne2_id",      0, 6'b000101, 0, 0, 1, IDN);
        add("bne_z1",       0, 6'b000101, 0, 1, 1, BRN);
        add("jal_if",       0, 6'b000011, 0, 0, 1, IFR);
        add("jal_id",       0, 6'b000011, 0, 0, 1, IDJAL);
        add("j_if",         0, 6'b000010, 0, 0, 1, IFR);
        add("j_id",         0, 6'b000010, 0, 0, 1, IDJ);
        add("jr_if",        0, R, 6'b001000, 0, 1, IFR);
        add("jr_id",        0, R, 6'b001000, 0, 1, IDJR);
        add("illop_if",     0, 6'b111111, 0, 0, 1, IFR);
        add("illop_id",     0, 6'b111111, 0, 0, 1, IDILL);
        add("illfn_if",     0, R, 6'b111111, 0, 1, IFR);
        add("illfn_id",     0, R, 6'b111111, 0, 1, IDILL);
        add("sll_if",       0, R, 6'b000000, 0, 1, IFR);
        add("sll_id",       0, R, 6'b000000, 0, 1, IDN);
        add("sll_exe",      0, R, 6'b000000, 0, 1, EXSLL);
        add("sll_wb",       0, R, 6'b000000, 0, 1, WBR);
        add("addi_if",      0, 6'b001000, 0, 0, 1, IFR);
        add("addi_id",      0, 6'b001000, 0, 0, 1, IDN);
        add("addi_exe",     0, 6'b001000, 0, 0, 1, EXIMM);
        add("addi_wb",      0, 6'b001000, 0, 0, 1, WBI);
        add("ori_if",       0, 6'b001101, 0, 0, 1, IFR);
        add("ori_id",       0, 6'b001101, 0, 0, 1, IDN);
        add("ori_exe",      0, 6'b001101, 0, 0, 1, EXORI);
        add("ori_wb",       0, 6'b001101, 0, 0, 1, WBI);
        add("lui_if",       0, 6'b001111, 0, 0, 1, IFR);
        add("lui_id",       0, 6'b001111, 0, 0, 1, IDN);
        add("lui_exe",      0, 6'b001111, 0, 0, 1, EXLUI);
        add("lui_wb",       0, 6'b001111, 0, 0, 1, WBI);
        add("sra_if",       0, R, 6'b000011, 0, 1, IFR);
        add("sra_id",       0, R, 6'b000011, 0, 1, IDN);
        add("sra_exe",      0, R, 6'b000011, 0, 1, EXSRA);
        add("sra_wb",       0, R, 6'b000011, 0, 1, WBR);
        add("sw_if",        0, 6'b101011, 0, 0, 1, IFR);
        add("sw_id",        0, 6'b101011, 0, 0, 1, IDN);
        add("sw_exe",       0, 6'b101011, 0, 0, 1, EXIMM);
        add("sw_mem_rdy",   0, 6'b101011, 0, 0, 1, MEMSW);
        add("sw2_if",       0, 6'b101011, 0, 0, 1, IFR);
        add("sw2_id",       0, 6'b101011, 0, 0, 1, IDN);
        add("sw2_exe",      0, 6'b101011, 0, 0, 1, EXIMM);
        add("sw2_mem_wait", 0, 6'b101011, 0, 0, 0, MEMSW);
        add("sw2_reset",    1, 6'b101011, 0, 0, 1, IFN);
        add("after_reset",  0, R, 6'b100000, 0, 1, IFR);

        foreach (vecs[i]) begin
            @(negedge clock);
            reset     = vecs[i].rst;
            op        = vecs[i].op;
            func      = vecs[i].func;
            z         = vecs[i].z;
            mem_ready = vecs[i].rdy;
            #1;
            check(vecs[i].name, {9'd0, got_vec()}, {9'd0, vecs[i].exp});
        end

        // lw with two MEM wait states, driven reactively: expect 7 cycles total.
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        op = 6'b100011; func = 6'd0; z = 1'b0; mem_ready = 1'b1;
        cycles = 0; waits = 0; done = 0; iord_ok = 1; wb_ok = 1;
        for (int c = 0; c < 30 && !done; c++) begin
            if (c != 0) @(negedge clock);
            if (cycles > 0 && state == 3'b000) begin
                done = 1;
            end else begin
                if (state == 3'b011) begin
                    mem_ready = (waits >= 2);
                    if (!mem_ready) waits++;
                end else begin
                    mem_ready = 1'b1;
                end
                #1;
                if (state == 3'b011 && iord !== 1'b1) iord_ok = 0;
                if (state == 3'b100 && !(m2reg === 1'b1 && wreg === 1'b1)) wb_ok = 0;
                cycles++;
            end
        end
        check("lw_seq_done", {31'd0, done}, 32'd1);
        check("lw_seq_cycles", cycles, 32'd7);
        check("lw_seq_iord", {31'd0, iord_ok}, 32'd1);
        check("lw_seq_wb", {31'd0, wb_ok}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
